// File: rtl/cnt_pkg.sv
// Shared types for the counter sequencer: FSM state encoding and command opcodes.
package cnt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic [1:0] OP_NOP    = 2'b00;
    localparam logic [1:0] OP_START  = 2'b01;
    localparam logic [1:0] OP_TOGGLE = 2'b10;
    localparam logic [1:0] OP_STOP   = 2'b11;

endpackage

// File: rtl/cnt_core.sv
// W-bit up-counter: clr wins, otherwise increments when en and not hold.
// term flags cnt==limit so the controller can decide terminal handling.
module cnt_core #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic         hold,
    input  logic [W-1:0] limit,
    output logic [W-1:0] cnt,
    output logic         term
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !hold) begin
            cnt <= cnt + W'(1);
        end
    end

    assign term = (cnt == limit);

endmodule

// File: rtl/cnt_seq_ctrl.sv
// Command-driven sequencer around cnt_core: start/pause/stop over valid/ready,
// one-shot or periodic terminal count with a registered one-cycle done pulse.
module cnt_seq_ctrl
    import cnt_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [W-1:0] cmd_limit,
    input  logic         cmd_mode,
    output logic [W-1:0] cnt,
    output logic         busy,
    output logic         paused,
    output logic         done
);

    state_t       state, state_n;
    logic [W-1:0] limit_q;
    logic         mode_q;
    logic         accept;
    logic         clr, en, hold, load, done_n;
    logic         term;

    cnt_core #(.W(W)) u_core (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .en    (en),
        .hold  (hold),
        .limit (limit_q),
        .cnt   (cnt),
        .term  (term)
    );

    assign cmd_ready = (state != ST_DONE);
    assign busy      = (state == ST_RUN) || (state == ST_PAUSE);
    assign paused    = (state == ST_PAUSE);
    assign accept    = cmd_valid && cmd_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            limit_q <= '0;
            mode_q  <= 1'b0;
            done    <= 1'b0;
        end else begin
            state <= state_n;
            done  <= done_n;
            if (load) begin
                limit_q <= cmd_limit;
                mode_q  <= cmd_mode;
            end
        end
    end

    // An accepted command in RUN/PAUSE takes precedence over the count update.
    always_comb begin
        state_n = state;
        clr     = 1'b0;
        en      = 1'b0;
        hold    = 1'b0;
        load    = 1'b0;
        done_n  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (accept && cmd_op == OP_START) begin
                    state_n = ST_RUN;
                    clr     = 1'b1;
                    load    = 1'b1;
                end
            end
            ST_RUN, ST_PAUSE: begin
                en = (state == ST_RUN);
                if (accept && cmd_op == OP_START) begin
                    state_n = ST_RUN;
                    clr     = 1'b1;
                    load    = 1'b1;
                end else if (accept && cmd_op == OP_STOP) begin
                    state_n = ST_IDLE;
                    clr     = 1'b1;
                end else if (accept && cmd_op == OP_TOGGLE) begin
                    state_n = (state == ST_RUN) ? ST_PAUSE : ST_RUN;
                    hold    = 1'b1;
                end else if (state == ST_RUN && term) begin
                    done_n = 1'b1;
                    if (mode_q) begin
                        clr = 1'b1;
                    end else begin
                        hold    = 1'b1;
                        state_n = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Directed plus random stimulus for cnt_seq_ctrl, checked against a behavioural model.
module tb_cnt_seq_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_op = 2'b00;
    logic [W-1:0] cmd_limit = '0;
    logic         cmd_mode = 1'b0;
    logic [W-1:0] cnt;
    logic         busy, paused, done;

    int total = 0;
    int bad   = 0;
    int dseen = 0;

    // Reference model: what the controller is doing, in plain terms.
    int m_cnt, m_lim;
    bit m_per, m_run, m_pause, m_fin, m_done;

    cnt_seq_ctrl #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_limit (cmd_limit),
        .cmd_mode  (cmd_mode),
        .cnt       (cnt),
        .busy      (busy),
        .paused    (paused),
        .done      (done)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_lim = 0; m_per = 0;
        m_run = 0; m_pause = 0; m_fin = 0; m_done = 0;
    endtask

    task automatic model_edge(input bit v, input bit [1:0] op, input int lim, input bit per);
        bit acc;
        acc = v && !m_fin;
        m_done = 0;
        if (m_fin) begin
            m_fin = 0;
        end else if (!m_run && !m_pause) begin
            if (acc && op == 2'd1) begin
                m_run = 1; m_cnt = 0; m_lim = lim; m_per = per;
            end
        end else if (acc && op == 2'd1) begin
            m_run = 1; m_pause = 0; m_cnt = 0; m_lim = lim; m_per = per;
        end else if (acc && op == 2'd3) begin
            m_run = 0; m_pause = 0; m_cnt = 0;
        end else if (acc && op == 2'd2) begin
            m_run = !m_run; m_pause = !m_pause;
        end else if (m_run) begin
            if (m_cnt == m_lim) begin
                m_done = 1;
                if (m_per) m_cnt = 0;
                else begin
                    m_run = 0; m_fin = 1;
                end
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".cnt"},    32'(cnt),       32'(m_cnt));
        check({tag, ".done"},   32'(done),      32'(m_done));
        check({tag, ".busy"},   32'(busy),      32'(m_run | m_pause));
        check({tag, ".paused"}, 32'(paused),    32'(m_pause));
        check({tag, ".ready"},  32'(cmd_ready), 32'(!m_fin));
    endtask

    task automatic cyc(input string tag, input bit v, input bit [1:0] op, input int lim, input bit per);
        @(negedge clk);
        cmd_valid = v;
        cmd_op    = op;
        cmd_limit = W'(lim);
        cmd_mode  = per;
        @(posedge clk);
        model_edge(v, op, lim, per);
        #1;
        compare_all(tag);
        if (done === 1'b1) dseen++;
    endtask

    task automatic nops(input string tag, input int n);
        for (int i = 0; i < n; i++) cyc(tag, 1'b0, 2'd0, int'($urandom_range(0, 15)), 1'($urandom));
    endtask

    initial begin
        model_reset();
        #5;
        compare_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // One-shot limit 5: exactly one done pulse, cnt held at 5 afterwards.
        dseen = 0;
        cyc("os_start", 1'b1, 2'd1, 5, 1'b0);
        nops("oneshot", 8);
        check("oneshot.pulses", 32'(dseen), 32'd1);
        check("oneshot.hold", 32'(cnt), 32'd5);

        // Periodic limit 3 for 12 cycles: three done pulses, busy throughout.
        dseen = 0;
        cyc("per_start", 1'b1, 2'd1, 3, 1'b1);
        nops("periodic", 12);
        check("periodic.pulses", 32'(dseen), 32'd3);
        cyc("per_stop", 1'b1, 2'd3, 0, 1'b0);

        // Pause at 6 for 5 cycles, resume, run to 15.
        cyc("pr_start", 1'b1, 2'd1, 15, 1'b0);
        nops("pr_run", 6);
        check("pr.at6", 32'(cnt), 32'd6);
        cyc("pr_pause", 1'b1, 2'd2, 0, 1'b1);
        nops("pr_paused", 5);
        check("pr.frozen", 32'(cnt), 32'd6);
        cyc("pr_resume", 1'b1, 2'd2, 0, 1'b0);
        dseen = 0;
        nops("pr_tail", 12);
        check("pr.pulses", 32'(dseen), 32'd1);

        // STOP accepted on the terminal edge suppresses done.
        cyc("st_start", 1'b1, 2'd1, 2, 1'b1);
        nops("st_run", 2);
        dseen = 0;
        cyc("st_stop", 1'b1, 2'd3, 0, 1'b0);
        check("stop.cnt", 32'(cnt), 32'd0);
        check("stop.nodone", 32'(dseen), 32'd0);

        // Limit 0 periodic: done every cycle.
        dseen = 0;
        cyc("l0_start", 1'b1, 2'd1, 0, 1'b1);
        nops("l0", 6);
        check("l0.pulses", 32'(dseen), 32'd6);

        // Limit 15 periodic: full range then back to 0 with done.
        cyc("l15_start", 1'b1, 2'd1, 15, 1'b1);
        nops("l15", 34);
        cyc("l15_stop", 1'b1, 2'd3, 0, 1'b0);

        // Asynchronous reset mid-run, checked before any clock edge.
        cyc("rr_start", 1'b1, 2'd1, 9, 1'b0);
        nops("rr_run", 4);
        @(negedge clk);
        cmd_valid = 1'b0;
        #2 rst = 1'b1;
        #3;
        model_reset();
        compare_all("async_rst");
        #20 rst = 1'b0;
        nops("post_rst", 2);

        // Random commands, limits and modes.
        for (int i = 0; i < 400; i++) begin
            int r;
            bit [1:0] op;
            r  = int'($urandom_range(0, 99));
            op = (r < 55) ? 2'd0 : (r < 75) ? 2'd1 : (r < 90) ? 2'd2 : 2'd3;
            cyc("rand", 1'($urandom_range(0, 3) != 0), op,
                int'($urandom_range(0, 15)), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
